// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and helpers for the data memory controller.
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_DBL  = 2'd3
  } dmem_size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } dmem_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic logic [3:0] nbytes(input dmem_size_e size);
    case (size)
      SZ_BYTE: nbytes = 4'd1;
      SZ_HALF: nbytes = 4'd2;
      SZ_WORD: nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_fmt.sv
`default_nettype none
// ============================================================================
// Module  : dmem_load_fmt
// Purpose : Big-endian load formatter; raw[63:56] is the byte at the address.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [63:0] raw,
  input  dmem_size_e  size,
  input  logic        sign_ext,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    case (size)
      SZ_BYTE: rdata1 = {{24{sign_ext & raw[63]}}, raw[63:56]};
      SZ_HALF: rdata1 = {{16{sign_ext & raw[63]}}, raw[63:48]};
      SZ_WORD: rdata1 = raw[63:32];
      default: begin
        rdata1 = raw[63:32];
        rdata2 = raw[31:0];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_ctrl
// Purpose : Clocked big-endian data memory with valid/ready request/response.
// Rev     : 1.0  initial release
// ============================================================================
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES      = 1024,
  parameter int ADDR_W           = 32,
  parameter int LATENCY          = 2,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata1,
  input  logic [31:0]       req_wdata2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata1,
  output logic [31:0]       resp_rdata2,
  output logic [1:0]        resp_err
);

  localparam int                  c_aw       = $clog2(DEPTH_BYTES);
  localparam int                  c_cnt_w    = $clog2(LATENCY + 1);
  // The wait spans LATENCY+1 edges after the accept edge.
  localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(LATENCY);
  localparam logic [ADDR_W:0]     c_depth    = (ADDR_W + 1)'(DEPTH_BYTES);

  dmem_state_e         r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  dmem_size_e          r_size;
  logic                r_write;
  logic                r_signed;
  logic [31:0]         r_wdata1;
  logic [31:0]         r_wdata2;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata1;
  logic [31:0]         r_resp_rdata2;
  logic [1:0]          r_resp_err;

  // The array stores the difference from the power-up image, so a
  // zero-initialised array reads back as that image without any reset.
  logic [7:0]          r_mem [DEPTH_BYTES] = '{default: 8'h00};

  logic [c_aw-1:0]     w_base;
  logic [3:0]          w_nb;
  logic [ADDR_W:0]     w_end;
  logic                w_mis;
  dmem_err_e           w_err;
  logic [63:0]         w_raw;
  logic [63:0]         w_wdata;
  logic [31:0]         w_fmt1;
  logic [31:0]         w_fmt2;
  logic                w_commit;
  logic                w_commit_wr;

  function automatic logic [7:0] f_image(input logic [c_aw-1:0] idx);
    logic [31:0] nxt;
    nxt = 32'(idx) + 32'd1;
    return (&idx[1:0]) ? nxt[7:0] : 8'h00;
  endfunction

  assign w_base      = r_addr[c_aw-1:0];
  assign w_nb        = nbytes(r_size);
  assign w_end       = {1'b0, r_addr} + (ADDR_W + 1)'(w_nb);
  assign w_commit    = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_commit_wr = w_commit && r_write && (w_err == ERR_OK);

  always_comb begin
    w_mis = 1'b0;
    case (r_size)
      SZ_HALF: w_mis = r_addr[0];
      SZ_WORD: w_mis = |r_addr[1:0];
      SZ_DBL:  w_mis = |r_addr[2:0];
      default: w_mis = 1'b0;
    endcase
    if (w_end > c_depth)
      w_err = ERR_RANGE;
    else if (w_mis && !ALLOW_MISALIGNED)
      w_err = ERR_MISALIGN;
    else
      w_err = ERR_OK;
  end

  always_comb begin
    w_wdata = '0;
    case (r_size)
      SZ_BYTE: w_wdata = {r_wdata1[7:0], 56'd0};
      SZ_HALF: w_wdata = {r_wdata1[15:0], 48'd0};
      SZ_WORD: w_wdata = {r_wdata1, 32'd0};
      default: w_wdata = {r_wdata1, r_wdata2};
    endcase
  end

  // Indices wrap inside the array; only in-range accesses ever use them.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < 8; k++) begin
      w_raw[63-8*k -: 8] = r_mem[w_base + c_aw'(k)] ^ f_image(w_base + c_aw'(k));
    end
  end

  always @(posedge clk) begin
    if (w_commit_wr) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(w_nb))
          r_mem[w_base + c_aw'(k)] <= w_wdata[63-8*k -: 8] ^ f_image(w_base + c_aw'(k));
      end
    end
  end

  dmem_load_fmt u_load_fmt (
    .raw      (w_raw),
    .size     (r_size),
    .sign_ext (r_signed),
    .rdata1   (w_fmt1),
    .rdata2   (w_fmt2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_size        <= SZ_BYTE;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_wdata1      <= '0;
      r_wdata2      <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata1 <= '0;
      r_resp_rdata2 <= '0;
      r_resp_err    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_size   <= dmem_size_e'(req_size);
            r_write  <= req_write;
            r_signed <= req_signed;
            r_wdata1 <= req_wdata1;
            r_wdata2 <= req_wdata2;
            r_cnt    <= c_cnt_load;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            if (!r_write && (w_err == ERR_OK)) begin
              r_resp_rdata1 <= w_fmt1;
              r_resp_rdata2 <= w_fmt2;
            end else begin
              r_resp_rdata1 <= '0;
              r_resp_rdata2 <= '0;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata1 = r_resp_rdata1;
  assign resp_rdata2 = r_resp_rdata2;
  assign resp_err    = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_ctrl
// Purpose : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against a byte-array reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int ALLOW = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata1 = 32'd0;
  logic [31:0] req_wdata2 = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata1;
  logic [31:0] resp_rdata2;
  logic [1:0]  resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .DEPTH_BYTES      (DEPTH),
    .ADDR_W           (32),
    .LATENCY          (LAT),
    .ALLOW_MISALIGNED (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata1  (req_wdata1),
    .req_wdata2  (req_wdata2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata1 (resp_rdata1),
    .resp_rdata2 (resp_rdata2),
    .resp_err    (resp_err)
  );

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [1:0]  ee;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain byte array, big-endian arithmetic.
  task automatic model_access(input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2,
                              output logic [31:0] r1, output logic [31:0] r2, output logic [1:0] e);
    int          n;
    longint      end_a;
    logic [63:0] v;
    logic [63:0] src;
    n     = 1 << int'(sz);
    end_a = longint'(a) + longint'(n);
    r1 = 32'd0;
    r2 = 32'd0;
    e  = 2'd0;
    v  = 64'd0;
    if (end_a > longint'(DEPTH)) begin
      e = 2'd2;
    end else if (ALLOW == 0 && (int'(a) % n) != 0) begin
      e = 2'd1;
    end else if (wr) begin
      src = (n == 8) ? {d1, d2} : {32'd0, d1};
      for (int i = 0; i < n; i++)
        model_mem[int'(a) + i] = 8'(src >> (8 * (n - 1 - i)));
    end else begin
      for (int i = 0; i < n; i++)
        v = (v << 8) | 64'(model_mem[int'(a) + i]);
      if (sg && n < 4 && v >= (64'd1 << (8 * n - 1)))
        v = v + (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
      if (n == 8) begin
        r1 = v[63:32];
        r2 = v[31:0];
      end else begin
        r1 = v[31:0];
      end
    end
  endtask

  task automatic transact(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2,
                          output logic [31:0] r1, output logic [31:0] r2, output logic [1:0] e);
    int lat;
    bit busy_ready;
    busy_ready = 1'b0;
    check("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata1 = d1;
    req_wdata2 = d2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      if (req_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles expected %0d", lat, LAT + 1);
    end else begin
      check("latency", 64'(lat), 64'(LAT + 1));
    end
    check("busy_req_ready", 64'(busy_ready), 64'd0);
    r1 = resp_rdata1;
    r2 = resp_rdata2;
    e  = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r1, r2, m1, m2;
    logic [1:0]  e, me;
    int          n;
    int          pick;
    bit          wr, sg;
    logic [1:0]  sz;
    logic [31:0] a, prev_a;
    bit          prev_wr;

    for (int i = 0; i < DEPTH; i++)
      model_mem[i] = ((i % 4) == 3) ? 8'((i + 1) % 256) : 8'h00;

    // Directed vectors: {wr, size, signed, addr, wdata1, wdata2, exp1, exp2, err}
    vecs.push_back('{0, 2'd2, 0, 32'h0000_000C, 32'h0, 32'h0, 32'h0000_0010, 32'h0, 2'd0});
    vecs.push_back('{1, 2'd2, 0, 32'h0000_0022, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 2'd1});
    vecs.push_back('{0, 2'd2, 0, 32'h0000_0020, 32'h0, 32'h0, 32'h0000_0024, 32'h0, 2'd0});
    vecs.push_back('{1, 2'd3, 0, 32'h0000_0020, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd0, 1, 32'h0000_0027, 32'h0, 32'h0, 32'hFFFF_FF88, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd1, 0, 32'h0000_0024, 32'h0, 32'h0, 32'h0000_5566, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd3, 0, 32'h0000_0020, 32'h0, 32'h0, 32'h1122_3344, 32'h5566_7788, 2'd0});
    vecs.push_back('{0, 2'd3, 0, 32'h0000_03FC, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2});
    vecs.push_back('{0, 2'd0, 0, 32'h0000_03FF, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd0, 1, 32'h0000_03FB, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd3, 0, 32'h0000_03F8, 32'h0, 32'h0, 32'h0000_00FC, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd2, 0, 32'h0000_03FD, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2});
    vecs.push_back('{0, 2'd1, 0, 32'h0000_0011, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1});
    vecs.push_back('{1, 2'd1, 0, 32'h0000_0100, 32'h1234_ABCD, 32'h0, 32'h0, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd2, 1, 32'h0000_0100, 32'h0, 32'h0, 32'hABCD_0004, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd1, 1, 32'h0000_0100, 32'h0, 32'h0, 32'hFFFF_ABCD, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd0, 1, 32'h0000_0102, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd0, 1, 32'h0000_007F, 32'h0, 32'h0, 32'hFFFF_FF80, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd1, 1, 32'h0000_007E, 32'h0, 32'h0, 32'h0000_0080, 32'h0, 2'd0});
    vecs.push_back('{0, 2'd0, 0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2});
    vecs.push_back('{1, 2'd2, 0, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 2'd2});

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata1", 64'(resp_rdata1), 64'd0);
    check("rst_rdata2", 64'(resp_rdata2), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_req_ready2", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      transact(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].d1, vecs[i].d2, r1, r2, e);
      model_access(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].d1, vecs[i].d2, m1, m2, me);
      check($sformatf("vec%0d_rdata1", i), 64'(r1), 64'(vecs[i].e1));
      check($sformatf("vec%0d_rdata2", i), 64'(r2), 64'(vecs[i].e2));
      check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].ee));
    end

    // Backpressure: response held while resp_ready is low, next request waits.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_000C;
    @(posedge clk); #1;
    req_addr = 32'h0000_0030;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_resp_valid", i), 64'(resp_valid), 64'd1);
      check($sformatf("bp%0d_rdata1", i), 64'(resp_rdata1), 64'h10);
      check($sformatf("bp%0d_err", i), 64'(resp_err), 64'd0);
      check($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_release_resp_valid", 64'(resp_valid), 64'd0);
    check("bp_release_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_next_accepted", 64'(req_ready), 64'd0);
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_next_rdata1", 64'(resp_rdata1), 64'h34);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset during WAIT drops the uncommitted store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0040;
    req_wdata1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_req_ready2", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("midrst_resp_valid2", 64'(resp_valid), 64'd0);
    transact(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h0, r1, r2, e);
    check("midrst_load_rdata1", 64'(r1), 64'h44);
    check("midrst_load_err", 64'(e), 64'd0);

    // Randomized traffic against the reference model.
    prev_a  = 32'd0;
    prev_wr = 1'b0;
    for (int t = 0; t < 300; t++) begin
      wr   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      n    = 1 << int'(sz);
      pick = int'($urandom_range(0, 9));
      if (prev_wr && pick < 3)
        a = prev_a;
      else if (pick < 7)
        a = 32'($urandom_range(0, DEPTH - 1)) & ~32'(n - 1);
      else if (pick == 7)
        a = 32'($urandom_range(0, DEPTH - 1));
      else if (pick == 8)
        a = 32'($urandom_range(DEPTH - 8, DEPTH + 7));
      else
        a = $urandom;
      if (prev_wr && pick < 3) wr = 1'b0;
      transact(wr, sz, sg, a, $urandom, $urandom, r1, r2, e);
      model_access(wr, sz, sg, a, req_wdata1, req_wdata2, m1, m2, me);
      check($sformatf("rnd%0d_rdata1", t), 64'(r1), 64'(m1));
      check($sformatf("rnd%0d_rdata2", t), 64'(r2), 64'(m2));
      check($sformatf("rnd%0d_err", t), 64'(e), 64'(me));
      prev_a  = a;
      prev_wr = wr;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
